// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared data-SRAM port.
// Registered strobes, fixed-latency read return through a small FSM.
module mem_port_arbiter #(
    parameter int D_BITS = 32,
    parameter int A_BITS = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req0,
    input  logic              we0,
    input  logic [A_BITS-1:0] addr0,
    input  logic [D_BITS-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [A_BITS-1:0] addr1,
    input  logic [D_BITS-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [D_BITS-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [A_BITS-1:0] mem_addr,
    output logic [D_BITS-1:0] mem_wdata,
    input  logic [D_BITS-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t            state, state_nx;
    logic              last, last_nx;
    logic [2:0]        cnt, cnt_nx;
    logic              sel, we_sel;
    logic              gnt0_nx, gnt1_nx;
    logic              rvalid0_nx, rvalid1_nx;
    logic [D_BITS-1:0] rdata_nx;
    logic              mem_read_nx, mem_write_nx;
    logic [A_BITS-1:0] mem_addr_nx;
    logic [D_BITS-1:0] mem_wdata_nx;
    logic              busy_nx;

    // Next-state and next-output logic; every output is computed one cycle ahead.
    always_comb begin
        state_nx     = state;
        last_nx      = last;
        cnt_nx       = cnt;
        sel          = 1'b0;
        we_sel       = 1'b0;
        gnt0_nx      = 1'b0;
        gnt1_nx      = 1'b0;
        rvalid0_nx   = 1'b0;
        rvalid1_nx   = 1'b0;
        rdata_nx     = rdata;
        mem_read_nx  = 1'b0;
        mem_write_nx = 1'b0;
        mem_addr_nx  = '0;
        mem_wdata_nx = '0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    sel         = (req0 && req1) ? ~last : req1;
                    we_sel      = sel ? we1 : we0;
                    last_nx     = sel;
                    state_nx    = GRANT;
                    gnt0_nx     = ~sel;
                    gnt1_nx     = sel;
                    mem_addr_nx = sel ? addr1 : addr0;
                    if (we_sel) begin
                        mem_write_nx = 1'b1;
                        mem_wdata_nx = sel ? wdata1 : wdata0;
                    end else begin
                        mem_read_nx = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (mem_write) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_nx = cnt - 3'd1;
                end else begin
                    rdata_nx   = mem_rdata;
                    rvalid0_nx = ~last;
                    rvalid1_nx = last;
                    state_nx   = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and registered outputs; reset drops any in-flight read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cnt       <= 3'd0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            cnt       <= cnt_nx;
            gnt0      <= gnt0_nx;
            gnt1      <= gnt1_nx;
            rvalid0   <= rvalid0_nx;
            rvalid1   <= rvalid1_nx;
            rdata     <= rdata_nx;
            mem_read  <= mem_read_nx;
            mem_write <= mem_write_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            busy      <= busy_nx;
        end
    end

    a_one_gnt: assert property (@(posedge clk) disable iff (!nrst)
        !(gnt0 && gnt1));
    a_one_rvalid: assert property (@(posedge clk) disable iff (!nrst)
        !(rvalid0 && rvalid1));
    a_one_strobe: assert property (@(posedge clk) disable iff (!nrst)
        !(mem_read && mem_write));

endmodule
